// File: rtl/lane_route_pkg.sv
// Shared definitions for the lane route buffer and its neighbours (LUT controller, MAC stage 2).
package lane_route_pkg;

  localparam int unsigned DefNumLanes = 10;
  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefIdxW     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StDone
  } lane_state_e;

endpackage

// File: rtl/lane_select.sv
// NUM_LANES:1 read mux returning the lane addressed by idx.
module lane_select
  import lane_route_pkg::*;
#(
  parameter int unsigned NUM_LANES = DefNumLanes,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned IDX_W     = DefIdxW
) (
  input  logic [NUM_LANES*DATA_W-1:0] lanes,
  input  logic [IDX_W-1:0]            idx,
  output logic [DATA_W-1:0]           sel_data
);

  // Out-of-range indices read as zero; idx never leaves 0..NUM_LANES-1 in practice.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (idx == IDX_W'(i)) sel_data = lanes[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/lane_route_buffer.sv
// Captures a vector of lanes, walks each lane through the shared activation LUT and
// writes the result back in place, then presents the whole vector to MAC stage 2.
module lane_route_buffer
  import lane_route_pkg::*;
#(
  parameter int unsigned NUM_LANES = DefNumLanes,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned IDX_W     = DefIdxW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mac_valid,
  output logic                        mac_ready,
  input  logic [NUM_LANES*DATA_W-1:0] mac_data,
  input  logic                        bypass,
  output logic                        lut_req_valid,
  input  logic                        lut_req_ready,
  output logic [DATA_W-1:0]           lut_req_data,
  output logic [IDX_W-1:0]            lut_req_idx,
  input  logic                        lut_rsp_valid,
  output logic                        lut_rsp_ready,
  input  logic [DATA_W-1:0]           lut_rsp_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [NUM_LANES*DATA_W-1:0] res_data,
  output logic                        busy
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_LANES - 1);

  lane_state_e                 state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_LANES*DATA_W-1:0] buf_q, buf_d;
  logic [NUM_LANES-1:0]        lane_we;
  logic                        load;
  logic                        rsp_fire;

  // mac_ready is only high in idle, so the handshake reduces to idle & valid.
  assign load     = (state_q == StIdle) && mac_valid;
  assign rsp_fire = (state_q == StWait) && lut_rsp_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic: one LUT request outstanding, last lane exits straight to done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mac_valid) state_d = bypass ? StDone : StSend;
      StSend: if (lut_req_ready) state_d = StWait;
      StWait: if (lut_rsp_valid) state_d = (idx_q == LastIdx) ? StDone : StSend;
      StDone: if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Per-lane write enables: only the lane being serviced takes the LUT result.
  always_comb begin
    lane_we = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_we[i] = rsp_fire && (idx_q == IDX_W'(i));
    end
  end

  // Buffer and lane index next values.
  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (load) begin
      buf_d = mac_data;
      idx_d = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (lane_we[i]) buf_d[i*DATA_W +: DATA_W] = lut_rsp_data;
      end
      if (rsp_fire && (idx_q != LastIdx)) idx_d = idx_q + IDX_W'(1);
    end
  end

  // Buffer and lane index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      idx_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    mac_ready     = (state_q == StIdle);
    lut_req_valid = (state_q == StSend);
    lut_rsp_ready = (state_q == StWait);
    res_valid     = (state_q == StDone);
    busy          = (state_q != StIdle);
  end

  lane_select #(
    .NUM_LANES (NUM_LANES),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_lane_select (
    .lanes    (buf_q),
    .idx      (idx_q),
    .sel_data (lut_req_data)
  );

  assign lut_req_idx = idx_q;
  assign res_data    = buf_q;

endmodule
